// File: rtl/sseg_frame_decoder.sv
// Purpose : passive monitor for a multiplexed active-low 7-segment bus; rebuilds hex frames.
// Latency : digit captured 2 + STABLE_CYCLES clk edges after its pins settle; frame out 1 edge later.
// Backpr. : frame held stable until frame_valid && frame_ready; a frame completing while held is dropped (overrun).
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   sseg_n[6:0]    - segment lines a..g, active-low, asynchronous to clk
//   an_n[N-1:0]    - anode enables, active-low, asynchronous to clk
//   frame_ready    - consumer accepts the presented frame
//   frame_valid    - frame_digits/frame_ok/frame_blank hold a complete frame
//   frame_digits   - decoded nibbles, digit i at [4i+3:4i]
//   frame_ok       - bit i set when digit i matched a hex glyph
//   frame_blank    - bit i set when digit i was all segments off
//   overrun        - sticky, a completed frame was dropped while one was pending
module sseg_frame_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              sseg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_ok,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = 7 + NUM_DIGITS;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // One decoded digit slot.
  typedef struct packed {
    logic [3:0] nib;
    logic       ok;
    logic       blank;
  } slot_t;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers. The bus is sampled, never timed, so per-bit skew
  // across a digit change just shows up as a short unstable burst that the
  // stability counter filters out.
  // ---------------------------------------------------------------------------
  logic [6:0]            sseg_m, sseg_s;
  logic [NUM_DIGITS-1:0] an_m, an_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sseg_m <= '0;
      sseg_s <= '0;
      an_m   <= '0;
      an_s   <= '0;
    end else begin
      sseg_m <= sseg_n;
      sseg_s <= sseg_m;
      an_m   <= an_n;
      an_s   <= an_m;
    end
  end

  logic [SW-1:0]         samp;
  logic [NUM_DIGITS-1:0] an_act;
  logic                  an_ok;

  assign samp   = {an_s, sseg_s};
  assign an_act = ~an_s;
  // Exactly one anode driven: non-zero and a power of two.
  assign an_ok  = (an_act != '0) &&
                  ((an_act & (an_act - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == '0);

  // ---------------------------------------------------------------------------
  // Glyph decode of the synchronized segment sample.
  // ---------------------------------------------------------------------------
  slot_t dec;

  always_comb begin
    dec = '0;
    case (sseg_s)
      7'b1000000: dec = '{nib: 4'h0, ok: 1'b1, blank: 1'b0};
      7'b1111001: dec = '{nib: 4'h1, ok: 1'b1, blank: 1'b0};
      7'b0100100: dec = '{nib: 4'h2, ok: 1'b1, blank: 1'b0};
      7'b0110000: dec = '{nib: 4'h3, ok: 1'b1, blank: 1'b0};
      7'b0011001: dec = '{nib: 4'h4, ok: 1'b1, blank: 1'b0};
      7'b0010010: dec = '{nib: 4'h5, ok: 1'b1, blank: 1'b0};
      7'b0000010: dec = '{nib: 4'h6, ok: 1'b1, blank: 1'b0};
      7'b1111000: dec = '{nib: 4'h7, ok: 1'b1, blank: 1'b0};
      7'b0000000: dec = '{nib: 4'h8, ok: 1'b1, blank: 1'b0};
      7'b0010000: dec = '{nib: 4'h9, ok: 1'b1, blank: 1'b0};
      7'b0001000: dec = '{nib: 4'hA, ok: 1'b1, blank: 1'b0};
      7'b0000011: dec = '{nib: 4'hB, ok: 1'b1, blank: 1'b0};
      7'b1000110: dec = '{nib: 4'hC, ok: 1'b1, blank: 1'b0};
      7'b0100001: dec = '{nib: 4'hD, ok: 1'b1, blank: 1'b0};
      7'b0000110: dec = '{nib: 4'hE, ok: 1'b1, blank: 1'b0};
      7'b0001110: dec = '{nib: 4'hF, ok: 1'b1, blank: 1'b0};
      7'b1111111: dec = '{nib: 4'h0, ok: 1'b0, blank: 1'b1};
      default:    dec = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stability FSM. prev holds the full sample (anodes + segments) so that a
  // digit switch with an identical glyph still restarts the count.
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] prev;
  logic          same;
  logic          cap;

  assign same = (samp == prev);
  // Capture on the edge whose increment brings the count to STABLE_CYCLES.
  assign cap  = (state == ST_COUNT) && an_ok && same && (cnt == CNT_MAX - CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
      cnt   <= '0;
      prev  <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (an_ok) begin
            cnt   <= CNT_ONE;
            prev  <= samp;
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!an_ok) begin
            state <= ST_WAIT;
          end else if (!same) begin
            cnt  <= CNT_ONE;
            prev <= samp;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            if (cnt == CNT_MAX - CNT_ONE) state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (!same) begin
            if (an_ok) begin
              cnt   <= CNT_ONE;
              prev  <= samp;
              state <= ST_COUNT;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Working frame, seen mask and output frame register.
  // A capture can never land on the completion edge (a capture always leaves
  // the FSM in HELD), but the seen update is still ordered clear-then-set.
  // ---------------------------------------------------------------------------
  slot_t                 work [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen;
  logic                  seen_full;
  logic                  take;

  assign seen_full = &seen;
  assign take      = seen_full && (!frame_valid || frame_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) work[i] <= '0;
      seen         <= '0;
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_ok     <= '0;
      frame_blank  <= '0;
      overrun      <= 1'b0;
    end else begin
      if (cap) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_act[i]) work[i] <= dec;
        end
      end

      seen <= (seen_full ? {NUM_DIGITS{1'b0}} : seen) | (cap ? an_act : {NUM_DIGITS{1'b0}});

      if (take) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          frame_digits[4*i +: 4] <= work[i].nib;
          frame_ok[i]            <= work[i].ok;
          frame_blank[i]         <= work[i].blank;
        end
        frame_valid <= 1'b1;
      end else if (seen_full) begin
        // Pending frame not taken this cycle: the new one is lost.
        overrun <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sseg_frame_decoder.sv
module tb_sseg_frame_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    sseg_n = 7'h7F;
  logic [ND-1:0] an_n = '1;
  logic          frame_ready = 1'b0;
  logic          frame_valid;
  logic [4*ND-1:0] frame_digits;
  logic [ND-1:0] frame_ok;
  logic [ND-1:0] frame_blank;
  logic          overrun;

  sseg_frame_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sseg_n       (sseg_n),
    .an_n         (an_n),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .frame_digits (frame_digits),
    .frame_ok     (frame_ok),
    .frame_blank  (frame_blank),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Hex glyph table, index = nibble value.
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: a digit shown for at least SC cycles is captured; when
  // every digit has been captured the frame is complete.
  logic [5:0]  m_slot [ND];   // {blank, ok, nibble}
  logic [ND-1:0] m_seen;
  logic [23:0] exp_q [$];
  logic [23:0] got_q [$];     // {digits, ok, blank} of each handshake

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return {2'b01, 4'(i)};
    if (p == 7'h7F) return 6'b100000;
    return 6'b000000;
  endfunction

  function automatic logic [23:0] m_frame();
    logic [23:0] f;
    f = '0;
    for (int i = 0; i < ND; i++) begin
      f[8 + 4*i +: 4] = m_slot[i][3:0];
      f[4 + i]        = m_slot[i][4];
      f[i]            = m_slot[i][5];
    end
    return f;
  endfunction

  // Record every handshake, sampled well away from the clock edges.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && frame_valid && frame_ready)
      got_q.push_back({frame_digits, frame_ok, frame_blank});
  end

  task automatic show(input int d, input logic [6:0] p, input int cyc);
    sseg_n = p;
    an_n   = ~(4'b0001 << d);
    repeat (cyc) @(negedge clk);
    if (cyc >= SC) begin
      m_slot[d] = ref_decode(p);
      m_seen[d] = 1'b1;
      if (&m_seen) begin
        exp_q.push_back(m_frame());
        m_seen = '0;
      end
    end
  endtask

  task automatic idle(input int cyc);
    sseg_n = 7'h7F;
    an_n   = '1;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    sseg_n = 7'($urandom);
    an_n = 4'($urandom);
    frame_ready = 1'($urandom);
    repeat (3) @(negedge clk);
    n_chk++;
    if ({frame_valid, frame_digits, frame_ok, frame_blank, overrun} !== 26'd0)
      $display("FAIL reset_outputs: got %h expected 0", {frame_valid, frame_digits, frame_ok, frame_blank, overrun});
    else n_pass++;
    sseg_n = 7'h7F;
    an_n = '1;
    frame_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    m_seen = '0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_valid !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) $display("FAIL reset_release_idle: valid high %0d cycles, required 0", bad);
    else n_pass++;
    clear_queues();
  endtask

  task automatic test_basic();
    frame_ready = 1'b1;
    clear_queues();
    show(0, glyph[1], 10);
    show(1, glyph[2], 10);
    show(2, glyph[10], 10);
    show(3, glyph[15], 10);
    idle(8);
    n_chk++;
    if (got_q.size() != 1) $display("FAIL basic_count: got %0d frames, required 1", got_q.size());
    else begin
      n_pass++;
      n_chk++;
      if (got_q[0] !== {16'hFA21, 4'hF, 4'h0})
        $display("FAIL basic_frame: got %h expected %h", got_q[0], {16'hFA21, 4'hF, 4'h0});
      else n_pass++;
    end
    clear_queues();
  endtask

  task automatic test_glitch();
    frame_ready = 1'b1;
    clear_queues();
    show(0, glyph[0], 6);
    show(1, glyph[1], 6);
    show(3, glyph[3], 6);
    show(2, glyph[2], 3);      // too short: rejected
    idle(10);
    n_chk++;
    if (got_q.size() != 0 || frame_valid !== 1'b0)
      $display("FAIL glitch_reject: got %0d frames valid=%b, required 0 frames", got_q.size(), frame_valid);
    else n_pass++;
    // Exactly SC cycles on the pins: capture on edge 2+SC, frame one edge later.
    sseg_n = glyph[2];
    an_n = 4'b1011;
    repeat (4) @(negedge clk);
    sseg_n = 7'h7F;
    an_n = '1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b0) $display("FAIL glitch_early: valid=%b at edge 6, required 0", frame_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b1 || frame_digits !== 16'h3210)
      $display("FAIL glitch_capture_time: valid=%b digits=%h at edge 7, required 1/3210", frame_valid, frame_digits);
    else n_pass++;
    idle(6);
    m_seen = '0;
    clear_queues();
  endtask

  task automatic test_invalid_blank();
    frame_ready = 1'b1;
    clear_queues();
    show(0, glyph[3], 8);
    show(1, 7'b1010101, 8);
    show(2, glyph[7], 8);
    show(3, 7'b1111111, 8);
    idle(8);
    n_chk++;
    if (got_q.size() != 1) $display("FAIL invblank_count: got %0d frames, required 1", got_q.size());
    else begin
      n_pass++;
      n_chk++;
      if (got_q[0] !== {16'h0703, 4'b0101, 4'b1000})
        $display("FAIL invblank_frame: got %h expected %h", got_q[0], {16'h0703, 4'b0101, 4'b1000});
      else n_pass++;
    end
    clear_queues();
  endtask

  task automatic test_multi_anode();
    frame_ready = 1'b1;
    clear_queues();
    show(1, glyph[4], 8);
    show(2, glyph[5], 8);
    show(3, glyph[6], 8);
    sseg_n = glyph[8];
    an_n = 4'b1100;
    repeat (20) @(negedge clk);
    idle(4);
    n_chk++;
    if (got_q.size() != 0 || frame_valid !== 1'b0)
      $display("FAIL multi_anode_reject: got %0d frames, required 0", got_q.size());
    else n_pass++;
    show(0, glyph[9], 8);
    idle(8);
    n_chk++;
    if (got_q.size() != 1 || got_q[0] !== {16'h6549, 4'hF, 4'h0})
      $display("FAIL multi_anode_recover: got %0d frames first=%h expected %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 24'h0, {16'h6549, 4'hF, 4'h0});
    else n_pass++;
    clear_queues();
  endtask

  task automatic test_back_to_back();
    frame_ready = 1'b0;
    clear_queues();
    show(0, glyph[1], 8);
    show(1, glyph[3], 8);
    show(2, glyph[5], 8);
    show(3, glyph[7], 8);
    idle(8);
    n_chk++;
    if (frame_valid !== 1'b1 || frame_digits !== 16'h7531)
      $display("FAIL b2b_first: valid=%b digits=%h, required 1/7531", frame_valid, frame_digits);
    else n_pass++;
    show(0, glyph[8], 8);
    show(1, glyph[9], 8);
    show(2, glyph[10], 8);
    sseg_n = glyph[11];
    an_n = 4'b0111;
    repeat (6) @(negedge clk);   // captured on edge 6, completes on edge 7
    frame_ready = 1'b1;          // handshake lands on the completion edge
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b1 || frame_digits !== 16'hBA98 || overrun !== 1'b0)
      $display("FAIL b2b_overlap: valid=%b digits=%h overrun=%b, required 1/BA98/0",
               frame_valid, frame_digits, overrun);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b0) $display("FAIL b2b_release: valid=%b, required 0", frame_valid);
    else n_pass++;
    idle(8);
    n_chk++;
    if (got_q.size() != 2 || got_q[0][23:8] !== 16'h7531 || got_q[1][23:8] !== 16'hBA98)
      $display("FAIL b2b_order: got %0d handshakes, required 2 (7531 then BA98)", got_q.size());
    else n_pass++;
    m_seen = '0;
    clear_queues();
  endtask

  task automatic test_overrun();
    int unstable;
    frame_ready = 1'b0;
    clear_queues();
    show(0, glyph[12], 8);
    show(1, glyph[13], 8);
    show(2, glyph[14], 8);
    show(3, glyph[15], 8);
    idle(8);
    unstable = 0;
    for (int d = 0; d < ND; d++) begin
      sseg_n = glyph[2*d];
      an_n = ~(4'b0001 << d);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (frame_valid !== 1'b1 || frame_digits !== 16'hFEDC || frame_ok !== 4'hF) unstable++;
      end
    end
    idle(8);
    n_chk++;
    if (unstable != 0 || frame_digits !== 16'hFEDC)
      $display("FAIL overrun_hold: %0d unstable cycles digits=%h, required 0/FEDC", unstable, frame_digits);
    else n_pass++;
    n_chk++;
    if (overrun !== 1'b1) $display("FAIL overrun_flag: got %b, required 1", overrun);
    else n_pass++;
    frame_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (frame_valid !== 1'b0) $display("FAIL overrun_release: valid=%b, required 0", frame_valid);
    else n_pass++;
    idle(8);
    n_chk++;
    if (got_q.size() != 1 || overrun !== 1'b1)
      $display("FAIL overrun_after: handshakes=%0d overrun=%b, required 1/1", got_q.size(), overrun);
    else n_pass++;
    m_seen = '0;
    clear_queues();
  endtask

  task automatic test_reset_midframe();
    frame_ready = 1'b1;
    clear_queues();
    show(0, glyph[4], 8);
    show(1, glyph[8], 8);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_seen = '0;
    n_chk++;
    if (overrun !== 1'b0) $display("FAIL midreset_overrun: got %b, required 0", overrun);
    else n_pass++;
    show(2, glyph[12], 8);
    show(3, glyph[14], 8);
    idle(10);
    n_chk++;
    if (got_q.size() != 0) $display("FAIL midreset_discard: got %0d frames, required 0", got_q.size());
    else n_pass++;
    show(0, glyph[1], 8);
    show(1, glyph[0], 8);
    idle(8);
    n_chk++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0])
      $display("FAIL midreset_frame: got %0d frames first=%h expected %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 24'h0, (exp_q.size() > 0) ? exp_q[0] : 24'h0);
    else n_pass++;
    clear_queues();
  endtask

  task automatic test_random();
    logic [6:0] p, gp;
    int r, n;
    frame_ready = 1'b1;
    clear_queues();
    m_seen = '0;
    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d < ND; d++) begin
        r = $urandom_range(0, 9);
        if (r < 8) p = glyph[$urandom_range(0, 15)];
        else if (r == 8) p = 7'h7F;
        else p = 7'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          gp = p ^ 7'($urandom_range(1, 127));
          show(d, gp, $urandom_range(1, SC - 1));
        end
        show(d, p, $urandom_range(SC, SC + 6));
      end
    end
    idle(10);
    n_chk++;
    if (got_q.size() != exp_q.size())
      $display("FAIL random_count: got %0d frames, required %0d", got_q.size(), exp_q.size());
    else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL random_frame%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    clear_queues();
  endtask

  initial begin
    for (int i = 0; i < ND; i++) m_slot[i] = '0;
    m_seen = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_invalid_blank();
    test_multi_anode();
    test_back_to_back();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sseg_frame_decoder.md
Name: sseg_frame_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder. Passively samples a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode lines).
- Decodes each stable digit pattern back to a 4-bit hex value and assembles one value per digit into a frame.
- Presents each completed frame over a valid/ready handshake. Used as a board-level display monitor and as a self-check tap on the display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits/anode lines (1..8).
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is captured (2..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sseg_n  in  7  segment lines, active-low, bit0=a .. bit6=g, asynchronous to clk
- an_n  in  NUM_DIGITS  anode enables, active-low, bit i = digit i, asynchronous to clk
- frame_ready  in  1  consumer accepts frame
- frame_valid  out  1  frame outputs hold a complete frame
- frame_digits  out  4*NUM_DIGITS  decoded nibbles, digit i at [4i+3:4i]
- frame_ok  out  NUM_DIGITS  bit i = digit i matched a hex glyph
- frame_blank  out  NUM_DIGITS  bit i = digit i was all-off (7'b1111111)
- overrun  out  1  sticky: a completed frame was dropped

Behaviour:
- Reset (async assert, sync release) clears:
  - synchronizers, stability counter and capture state;
  - the working frame and its "seen" mask;
  - all outputs to 0. State goes to WAIT.
- Input sync: sseg_n and an_n each pass through 2 flops. All logic below uses the synchronized sample S = {an_s, sseg_s}.
- Glyph table (sseg_n -> nibble):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - 1111111 -> blank (nibble 0, ok=0, blank=1).
  - Any other pattern -> nibble 0, ok=0, blank=0.
- One-hot-low check: an_s is valid only when exactly one bit is 0.
- FSM states: WAIT, COUNT, HELD.
  - WAIT: if an_s is valid, load count=1, latch S into prev, go to COUNT. Otherwise stay.
  - COUNT: if an_s is invalid, go to WAIT. If S != prev, reload count=1, prev=S, stay. If S == prev, increment count. When the increment makes count == STABLE_CYCLES, capture on that edge and go to HELD.
  - HELD: stay while S == prev. Any change in S: if an_s is valid, go to COUNT with count=1 and prev=S; otherwise go to WAIT.
- Capture: write the decoded nibble, ok and blank into working slot i (the active digit) and set seen[i]. Re-capturing an already-seen digit overwrites its slot.
- Latency: a digit is captured 2 (sync) + STABLE_CYCLES clk edges after its pattern settles on the pins.
- Frame completion: when seen becomes all-ones, on the next edge:
  - if frame_valid=0: copy the working frame to the outputs, set frame_valid=1, clear seen;
  - if frame_valid=1 and no handshake happens that cycle: drop the new frame, set overrun=1, clear seen, keep the outputs unchanged.
- Handshake:
  - frame_valid and the frame outputs stay stable until frame_valid && frame_ready.
  - frame_valid clears on the edge after the handshake unless a completion loads on the same edge.
  - Simultaneous handshake and completion: the new frame loads, frame_valid stays 1, no overrun.
- overrun clears only on reset.
- Capture continues while frame_valid is held.
- Reset mid-capture discards any partial frame.
- Counter width is clog2(STABLE_CYCLES+1). The counter saturates and never wraps.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0. Release -> frame_valid stays 0 with an_n=4'b1111.
- Basic frame (STABLE_CYCLES=4, frame_ready=1): scan digits 0..3 showing 1,2,A,F (1111001, 0100100, 0001000, 0001110), 10 cycles each -> one frame_valid pulse with frame_digits=16'hFA21, frame_ok=4'hF, frame_blank=0.
- Glitch rejection: digit 2 pattern held 3 cycles then changed -> no capture. Held 4 cycles -> captured exactly 6 cycles after the pins settle.
- Invalid and blank: digit 1 = 1010101, digit 3 = 1111111, others valid -> frame_ok=4'b0101, frame_blank=4'b1000, nibbles 1 and 3 = 0.
- Multiple anodes: an_n=4'b1100 held 20 cycles -> no capture, FSM in WAIT. Then a valid digit -> normal capture.
- Backpressure: frame_ready=0 across two complete scans -> first frame held stable, second dropped, overrun=1. Raise frame_ready -> handshake then frame_valid=0. Simultaneous handshake and completion -> new frame loads, frame_valid stays 1.
